instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Sequential RV32I instruction encoder and instruction-memory loader. It accepts instruction fields over a valid/ready stream, packs them into 32-bit words for R, I-ALU, LOAD, S, B, JAL and JALR, buffers them in a small FIFO, and writes them to consecutive instruction-memory addresses. It produces exactly the opcode set that the main decoder consumes. It sits between the debug/boot host interface and instruction memory.

Parameters:
DEPTH, 4, FIFO entries (power of 2, minimum 2)
AW, 32, instruction-memory byte-address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latches base_addr; accepted only in IDLE
base_addr  in  AW  first write address (byte; bits[1:0] ignored, forced 0)
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
in_fmt  in  3  0=R 1=I-ALU 2=LOAD 3=S 4=B 5=JAL 6=JALR 7=illegal
in_rd/in_rs1/in_rs2  in  5 each  register fields
in_funct3  in  3  funct3 (ignored for JAL; forced 000 for JALR)
in_funct7  in  7  funct7 (R only)
in_imm  in  32  signed immediate, byte offset for B/J
in_last  in  1  marks the final bundle of the load sequence
imem_stall  in  1  memory cannot take a write this cycle
imem_we  out  1  write strobe
imem_addr  out  AW  write address
imem_wdata  out  32  encoded instruction
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last word is written
err  out  1  sticky; cleared by start

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, address counter 0.
- FSM IDLE -> LOAD on start, with addr <= {base_addr[AW-1:2],2'b00} and err <= 0.
- LOAD -> FLUSH when a bundle with in_last=1 is accepted.
- FLUSH -> DONE when the FIFO is empty and no write is pending.
- DONE -> IDLE unconditionally on the next cycle; done=1 only in DONE.
- in_ready = (state==LOAD) && FIFO not full. A bundle is accepted on in_valid && in_ready.
- Encoding is combinational at acceptance; the encoded word is pushed to the FIFO in the same cycle. Opcodes: R 0110011, I 0010011, LOAD 0000011, S 0100011, B 1100011, JAL 1101111, JALR 1100111.
- Field packing:
  - R: f7|rs2|rs1|f3|rd|op
  - I/LOAD/JALR: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Immediate range checks: imm must fit the signed field (I/S 12 bits, B 13 bits, J 21 bits), and B/J require imm[0]=0. On a violation, or on in_fmt=7, the bundle is accepted and dropped (not pushed), and err is set. in_last on a dropped bundle still moves the FSM to FLUSH.
- Write side: when the FIFO is non-empty and imem_stall=0, pop and drive imem_we=1 with the current addr and word. addr increments by 4 after each write and wraps modulo 2^AW.
- imem_we, addr and wdata are registered; write latency is 1 cycle from push into an empty FIFO.
- Simultaneous push and pop when full: not permitted, because in_ready is low. When the FIFO holds fewer than DEPTH entries, simultaneous push and pop keep the count unchanged.
- Stall holds the FIFO head. imem_we=0 during stall cycles.
- start outside IDLE is ignored. in_valid outside LOAD is not accepted.
- Asynchronous reset mid-sequence: immediate return to IDLE, FIFO flushed, no done pulse.

Decomposition:
- Shared package rv_pkg holds the 7-bit opcode constants (shared with the main decoder), the in_fmt enumeration and the FSM state encoding.
- One natural sub-module, sync_fifo (parameterised DEPTH/width, full/empty/count). The encoder mux and FSM remain in instr_encoder_loader.

Test Plan:
- start with base_addr=0x100, then I-ALU rd=1 rs1=0 f3=0 imm=5 with last=1 -> one write: addr 0x100, data 0x00500093; done pulses 1 cycle later; err=0.
- Sequence at base 0x0:
  - R add rd=3 rs1=1 rs2=2 -> 0x002081B3 at 0x0
  - S sw rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423 at 0x4
  - B beq rs1=1 rs2=2 imm=-4 -> 0xFE208EE3 at 0x8
  - JAL rd=1 imm=8, last -> 0x008000EF at 0xC
- Hold imem_stall=1 while pushing DEPTH+1 bundles -> in_ready drops after DEPTH accepts. Release stall -> words are written in order with no loss or duplicate.
- B with imm=3, then I with imm=2048 -> both dropped; err=1; no imem_we; a following valid bundle is still written.
- Assert rst low while the FIFO holds 2 entries -> outputs 0 immediately, busy=0, no later write, no done.
- start with base_addr=0xFFFFFFFC and two bundles -> writes land at 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the instruction encoder/loader and the main decoder.
// Contents:
//   OP_*      7-bit major opcodes; exactly the set the main decoder consumes.
//   fmt_t     host-side instruction format selector (in_fmt encoding).
//   state_t   loader FSM state encoding.
//   fits_signed()  true when a 32-bit value is representable in a signed field.
package rv_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_LOAD = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_JAL  = 3'd5,
    FMT_JALR = 3'd6,
    FMT_ILL  = 3'd7
  } fmt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A value fits a signed field of 'bits' width when every bit from the
  // field's sign position upward equals bit 31 (pure sign extension).
  function automatic logic fits_signed(input logic [31:0] value, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= bits - 1 && value[i] != value[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     write one entry (ignored while full)
//   pop             remove the head entry (ignored while empty)
//   rdata           current head entry (valid while !empty)
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and instruction-memory loader.
// Accepts field bundles from the boot/debug host, packs them into 32-bit
// instruction words, buffers them and writes them to consecutive word
// addresses of instruction memory starting at base_addr.
//
// Handshake: a bundle transfers on a rising clk edge where in_valid && in_ready
// are both 1. in_ready is high only in LOAD while the FIFO has room, and does
// not depend on in_valid. The host holds all in_* fields stable while in_valid
// is high and not yet accepted.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, base_addr         begin a load sequence (IDLE only), first byte address
//   in_valid/in_ready        bundle handshake
//   in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last
//                            instruction fields; in_last ends the sequence
//   imem_stall               memory cannot take a write this cycle
//   imem_we/imem_addr/imem_wdata   registered write port
//   busy, done, err          status: not idle, end-of-sequence pulse, sticky error
//   dbg_state, dbg_count     FSM state and FIFO occupancy for observation
module instr_encoder_loader
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AW-1:0]           base_addr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_fmt,
  input  logic [4:0]              in_rd,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic [2:0]              in_funct3,
  input  logic [6:0]              in_funct7,
  input  logic [31:0]             in_imm,
  input  logic                    in_last,
  input  logic                    imem_stall,
  output logic                    imem_we,
  output logic [AW-1:0]           imem_addr,
  output logic [31:0]             imem_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              dbg_state,
  output logic [$clog2(DEPTH):0]  dbg_count
);

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] addr;
  logic [31:0]   word;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  fmt_t          fmt;

  assign fmt = fmt_t'(in_fmt);

  // Encoder: pure function of the presented fields.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (fmt)
      FMT_R: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      FMT_I: begin
        word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
        legal = fits_signed(in_imm, 12);
      end
      FMT_LOAD: begin
        word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        legal = fits_signed(in_imm, 12);
      end
      FMT_JALR: begin
        word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
        legal = fits_signed(in_imm, 12);
      end
      FMT_S: begin
        word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
        legal = fits_signed(in_imm, 12);
      end
      FMT_B: begin
        word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], OP_B};
        legal = fits_signed(in_imm, 13) && !in_imm[0];
      end
      FMT_JAL: begin
        word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        legal = fits_signed(in_imm, 21) && !in_imm[0];
      end
      default: legal = 1'b0;
    endcase
  end

  assign in_ready = (state == ST_LOAD) && !fifo_full;
  assign accept   = in_valid && in_ready;
  // Illegal bundles are consumed from the host but never stored.
  assign push     = accept && legal;
  assign pop      = !fifo_empty && !imem_stall;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (dbg_count)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_LOAD;
      ST_LOAD:  if (accept && in_last) state_n = ST_FLUSH;
      // The final pop's registered strobe is on the port during the cycle the
      // FIFO reads empty, so DONE lands one cycle after the last write.
      ST_FLUSH: if (fifo_empty) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      addr       <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= state_n;
      imem_we <= pop;
      if (pop) begin
        imem_addr  <= addr;
        imem_wdata <= fifo_rdata;
      end
      if (state == ST_IDLE && start) begin
        addr <= base_addr & ~AW'(3);
        err  <= 1'b0;
      end else begin
        if (pop) addr <= addr + AW'(4);
        if (accept && !legal) err <= 1'b1;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader.
module tb_instr_encoder_loader;
  import rv_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic [AW-1:0]          base_addr;
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             in_fmt;
  logic [4:0]             in_rd;
  logic [4:0]             in_rs1;
  logic [4:0]             in_rs2;
  logic [2:0]             in_funct3;
  logic [6:0]             in_funct7;
  logic [31:0]            in_imm;
  logic                   in_last;
  logic                   imem_stall;
  logic                   imem_we;
  logic [AW-1:0]          imem_addr;
  logic [31:0]            imem_wdata;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [1:0]             dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;

  instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_stall (imem_stall),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state),
    .dbg_count  (dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic          first;
    logic [AW-1:0] base;
    logic [2:0]    fmt;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [31:0]   imm;
    logic          last;
    logic          drop;
    logic [31:0]   exp;
  } vec_t;

  function automatic vec_t mk(input logic first, input logic [AW-1:0] base,
                              input logic [2:0] fmt, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic last,
                              input logic drop, input logic [31:0] exp);
    vec_t v;
    v.first = first; v.base = base; v.fmt = fmt; v.rd = rd; v.rs1 = rs1;
    v.rs2 = rs2; v.f3 = f3; v.f7 = f7; v.imm = imm; v.last = last;
    v.drop = drop; v.exp = exp;
    return v;
  endfunction

  localparam int NV = 18;
  vec_t tbl [NV];

  // ---------------- scoreboard ----------------
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] exp_addr;
  logic          exp_err;
  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int last_wr_cyc = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (imem_we) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", imem_addr, imem_wdata);
      end else begin
        check("wr_addr", 64'(imem_addr), 64'(exp_addr_q.pop_front()));
        check("wr_data", 64'(imem_wdata), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [AW-1:0] base);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1;
    start    = 1'b0;
    exp_addr = base & ~AW'(3);
    exp_err  = 1'b0;
  endtask

  task automatic send(input vec_t v);
    bit accepted;
    int k;
    accepted  = 0;
    k         = 0;
    in_fmt    = v.fmt;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
    in_last   = v.last;
    in_valid  = 1'b1;
    while (!accepted && k < 200) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      else k++;
    end
    if (accepted) begin
      @(posedge clk);
      if (v.drop) begin
        exp_err = 1'b1;
      end else begin
        exp_q.push_back(v.exp);
        exp_addr_q.push_back(exp_addr);
        exp_addr = exp_addr + AW'(4);
      end
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, required 1");
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found;
    int k;
    found = 0;
    k     = 0;
    while (!found && k < 100) begin
      @(negedge clk);
      if (done) found = 1;
      else k++;
    end
    check({name, "_done_seen"}, 64'(found), 64'(1));
    if (found) begin
      check({name, "_done_latency"}, 64'(cyc), 64'(last_wr_cyc + 1));
      check({name, "_err"}, 64'(err), 64'(exp_err));
      check({name, "_pending"}, 64'(exp_q.size()), 64'(0));
      @(negedge clk);
      check({name, "_done_pulse_width"}, 64'(done), 64'(0));
      check({name, "_busy_after"}, 64'(busy), 64'(0));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int wr_before;
    int done_before;
    vec_t v;

    tbl[0]  = mk(1, 32'h100, FMT_I,    1, 0, 0, 0, 7'h00, 32'd5,         1, 0, 32'h0050_0093);
    tbl[1]  = mk(1, 32'h0,   FMT_R,    3, 1, 2, 0, 7'h00, 32'd0,         0, 0, 32'h0020_81B3);
    tbl[2]  = mk(0, 32'h0,   FMT_S,    0, 1, 2, 2, 7'h00, 32'd8,         0, 0, 32'h0020_A423);
    tbl[3]  = mk(0, 32'h0,   FMT_B,    0, 1, 2, 0, 7'h00, -32'sd4,       0, 0, 32'hFE20_8EE3);
    tbl[4]  = mk(0, 32'h0,   FMT_JAL,  1, 0, 0, 0, 7'h00, 32'd8,         1, 0, 32'h0080_00EF);
    tbl[5]  = mk(1, 32'h202, FMT_LOAD, 5, 2, 0, 2, 7'h00, 32'hFFFF_FFFF, 0, 0, 32'hFFF1_2283);
    tbl[6]  = mk(0, 32'h0,   FMT_JALR, 0, 1, 0, 5, 7'h00, 32'd0,         0, 0, 32'h0000_8067);
    tbl[7]  = mk(0, 32'h0,   FMT_R,    1, 2, 3, 0, 7'h20, 32'd0,         0, 0, 32'h4031_00B3);
    tbl[8]  = mk(0, 32'h0,   FMT_I,    1, 0, 0, 0, 7'h00, 32'd2047,      0, 0, 32'h7FF0_0093);
    tbl[9]  = mk(0, 32'h0,   FMT_I,    1, 0, 0, 0, 7'h00, -32'sd2048,    0, 0, 32'h8000_0093);
    tbl[10] = mk(0, 32'h0,   FMT_B,    0, 0, 0, 0, 7'h00, 32'd4094,      0, 0, 32'h7E00_0FE3);
    tbl[11] = mk(0, 32'h0,   FMT_JAL,  0, 0, 0, 0, 7'h00, -32'sd2,       0, 0, 32'hFFFF_F06F);
    tbl[12] = mk(0, 32'h0,   FMT_B,    0, 1, 2, 0, 7'h00, 32'd3,         0, 1, 32'h0);
    tbl[13] = mk(0, 32'h0,   FMT_I,    1, 0, 0, 0, 7'h00, 32'd2048,      0, 1, 32'h0);
    tbl[14] = mk(0, 32'h0,   FMT_ILL,  1, 0, 0, 0, 7'h00, 32'd0,         0, 1, 32'h0);
    tbl[15] = mk(0, 32'h0,   FMT_S,    0, 1, 2, 2, 7'h00, -32'sd2049,    0, 1, 32'h0);
    tbl[16] = mk(0, 32'h0,   FMT_JAL,  1, 0, 0, 0, 7'h00, 32'h0010_0000, 0, 1, 32'h0);
    tbl[17] = mk(0, 32'h0,   FMT_I,    1, 0, 0, 0, 7'h00, 32'd5,         1, 0, 32'h0050_0093);

    rst = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_fmt = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0;
    in_imm = '0; in_last = 1'b0; imem_stall = 1'b0; exp_addr = '0; exp_err = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_imem_we", 64'(imem_we), 64'(0));
    check("rst_imem_addr", 64'(imem_addr), 64'(0));
    check("rst_imem_wdata", 64'(imem_wdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_count", 64'(dbg_count), 64'(0));
    rst = 1'b1;

    // Table-driven runs: single word, the basic mix, boundaries and drops.
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].first) do_start(tbl[i].base);
      send(tbl[i]);
      if (tbl[i].last) wait_done($sformatf("vec%0d", i));
    end

    // Stall: DEPTH accepts fill the FIFO, the next bundle must wait.
    do_start(32'h40);
    imem_stall = 1'b1;
    wr_before  = wr_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      v = mk(0, 0, FMT_I, 5'(i + 1), 0, 0, 0, 7'h00, 32'(i * 16), 0, 0,
             {12'(i * 16), 5'd0, 3'd0, 5'(i + 1), OP_I});
      send(v);
    end
    // start outside IDLE must not move the address counter.
    start     = 1'b1;
    base_addr = 32'h0000_0990;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_count", 64'(dbg_count), 64'(DEPTH));
    end
    check("stall_no_write", 64'(wr_cnt), 64'(wr_before));
    imem_stall = 1'b0;
    send(mk(0, 0, FMT_I, 5'd9, 5'd1, 0, 0, 7'h00, 32'd7, 1, 0, 32'h0070_8493));
    wait_done("stall");

    // Asynchronous reset while two words are buffered.
    do_start(32'h80);
    imem_stall = 1'b1;
    send(mk(0, 0, FMT_I, 5'd1, 0, 0, 0, 7'h00, 32'd1, 0, 0, 32'h0010_0093));
    send(mk(0, 0, FMT_I, 5'd2, 0, 0, 0, 7'h00, 32'd2, 0, 0, 32'h0020_0113));
    @(negedge clk);
    check("pre_rst_count", 64'(dbg_count), 64'(2));
    wr_before   = wr_cnt;
    done_before = done_cnt;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_imem_we", 64'(imem_we), 64'(0));
    check("arst_imem_addr", 64'(imem_addr), 64'(0));
    check("arst_imem_wdata", 64'(imem_wdata), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_count", 64'(dbg_count), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(0));
    exp_q.delete();
    exp_addr_q.delete();
    imem_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_no_write", 64'(wr_cnt), 64'(wr_before));
    check("arst_no_done", 64'(done_cnt), 64'(done_before));
    check("arst_idle", 64'(dbg_state), 64'(ST_IDLE));

    // Address wrap at the top of the address space.
    do_start(32'hFFFF_FFFC);
    send(mk(0, 0, FMT_I, 5'd2, 0, 0, 0, 7'h00, 32'd1, 0, 0, 32'h0010_0113));
    send(mk(0, 0, FMT_I, 5'd3, 0, 0, 0, 7'h00, 32'd2, 1, 0, 32'h0020_0193));
    wait_done("wrap");
    check("wrap_final_addr", 64'(imem_addr), 64'(32'h0000_0000));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
